friet_c_lwc_deserializer_in: RTL and testbench

FRIET_C_LWC_DESERIALIZER_IN -- requirements
Module: friet_c_lwc_deserializer_in

---
 rtl/friet_c_lwc_deserializer_in.sv | 96 +++++++++
 tb/tb_friet_c_lwc_deserializer_in.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/friet_c_lwc_deserializer_in.sv
// Packs G_WIDTH-bit input words into G_BLOCK_WORDS-word blocks, zero-padding a
// short final block and flagging the block that holds the message's last word.
module friet_c_lwc_deserializer_in #(
    parameter int G_WIDTH       = 32,
    parameter int G_BLOCK_WORDS = 4,
    localparam int CW           = $clog2(G_BLOCK_WORDS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [G_WIDTH-1:0]                 din,
    input  logic                               din_last,
    input  logic                               din_valid,
    output logic                               din_ready,
    output logic [G_WIDTH*G_BLOCK_WORDS-1:0]   block_out,
    output logic [CW-1:0]                      block_words,
    output logic                               block_last,
    output logic                               block_valid,
    input  logic                               block_ready
);

    // state | meaning
    // FILL  | collecting words into the block, block_valid=0
    // FULL  | holding a finished block for downstream, block_valid=1
    typedef enum logic {FILL, FULL} state_t;

    state_t                             state, state_nxt;
    logic [CW-1:0]                      count, count_nxt;
    logic [G_WIDTH*G_BLOCK_WORDS-1:0]   data_q, data_nxt;
    logic                               last_q, last_nxt;
    logic                               in_xfer, out_xfer;

    assign block_valid = (state == FULL);
    // In FULL a word can only enter when the held block leaves on the same edge.
    assign din_ready   = !rst && ((state == FILL) || block_ready);
    assign in_xfer     = din_valid && din_ready;
    assign out_xfer    = block_valid && block_ready;

    assign block_out   = data_q;
    assign block_words = count;
    assign block_last  = last_q;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        data_nxt  = data_q;
        last_nxt  = last_q;
        case (state)
            FILL: begin
                if (in_xfer) begin
                    for (int i = 0; i < G_BLOCK_WORDS; i++) begin
                        if (count == CW'(i)) begin
                            data_nxt[i*G_WIDTH +: G_WIDTH] = din;
                        end
                    end
                    count_nxt = count + CW'(1);
                    if ((count == CW'(G_BLOCK_WORDS - 1)) || din_last) begin
                        state_nxt = FULL;
                        last_nxt  = din_last;
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_nxt = FILL;
                    count_nxt = '0;
                    data_nxt  = '0;
                    last_nxt  = 1'b0;
                    if (in_xfer) begin
                        data_nxt[G_WIDTH-1:0] = din;
                        count_nxt             = CW'(1);
                        if (din_last) begin
                            state_nxt = FULL;
                            last_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            count  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            data_q <= data_nxt;
            last_q <= last_nxt;
        end
    end

endmodule

// File: tb/tb_friet_c_lwc_deserializer_in.sv
// Bench for friet_c_lwc_deserializer_in: a cycle model checks every output each
// cycle and queues expected blocks that are compared when the DUT hands them off.
module tb_friet_c_lwc_deserializer_in;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [W-1:0]       din = '0;
    logic               din_last = 1'b0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic [W*N-1:0]     block_out;
    logic [CW-1:0]      block_words;
    logic               block_last;
    logic               block_valid;
    logic               block_ready = 1'b0;

    friet_c_lwc_deserializer_in #(.G_WIDTH(W), .G_BLOCK_WORDS(N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_last(din_last), .din_valid(din_valid),
        .din_ready(din_ready), .block_out(block_out), .block_words(block_words),
        .block_last(block_last), .block_valid(block_valid), .block_ready(block_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*N-1:0] data;
        int             words;
        logic           last;
    } blk_t;

    blk_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   blk_cnt = 0;
    int   last_cnt = 0;
    int   last_idx = 0;
    bit   mon_on  = 1'b0;

    logic [W*N-1:0] m_acc  = '0;
    int             m_cnt  = 0;
    logic           m_full = 1'b0;
    logic           m_last = 1'b0;

    task automatic check(input string tag, input logic [W*N-1:0] got, input logic [W*N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model of the next rising edge, evaluated on the falling edge with stable inputs.
    always @(negedge clk) begin
        logic exp_rdy;
        blk_t e;
        if (mon_on) begin
            exp_rdy = rst ? 1'b0 : (m_full ? block_ready : 1'b1);
            check("din_ready", din_ready, exp_rdy);
            check("block_valid", block_valid, m_full);
            check("block_words", block_words, m_cnt);
            check("block_last", block_last, m_last);
            check("block_out", block_out, m_acc);
            if (rst) begin
                m_acc = '0; m_cnt = 0; m_full = 1'b0; m_last = 1'b0;
                sb.delete();
            end else begin
                if (block_valid && block_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_block", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_data", block_out, e.data);
                        check("sb_words", block_words, e.words);
                        check("sb_last", block_last, e.last);
                        blk_cnt++;
                        if (block_last) begin
                            last_cnt++;
                            last_idx = blk_cnt;
                        end
                    end
                end
                if (m_full && block_ready) begin
                    m_acc = '0; m_cnt = 0; m_full = 1'b0; m_last = 1'b0;
                end
                if (din_valid && exp_rdy) begin
                    m_acc[m_cnt*W +: W] = din;
                    m_cnt++;
                    if (m_cnt == N || din_last) begin
                        m_full = 1'b1;
                        m_last = din_last;
                        e.data = m_acc; e.words = m_cnt; e.last = din_last;
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        logic acc;
        din = d; din_last = l; din_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, l0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", block_valid, 0);
        check("rst_words", block_words, 0);
        check("rst_ready", din_ready, 1);
        @(posedge clk); #1;

        // Full block
        block_ready = 1'b1;
        send(32'h11111111, 0); send(32'h22222222, 0);
        send(32'h33333333, 0); send(32'h44444444, 0);
        idle();
        @(negedge clk);
        check("full_out", block_out, 128'h44444444_33333333_22222222_11111111);
        check("full_words", block_words, 4);
        check("full_last", block_last, 0);
        check("full_valid", block_valid, 1);
        @(posedge clk); #1;

        // Partial last block
        send(32'hAAAAAAAA, 0); send(32'hBBBBBBBB, 1);
        idle();
        @(negedge clk);
        check("part_out", block_out, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
        check("part_words", block_words, 2);
        check("part_last", block_last, 1);
        @(posedge clk); #1;

        // Backpressure
        block_ready = 1'b0;
        send(32'hC0000001, 0); send(32'hC0000002, 0);
        send(32'hC0000003, 0); send(32'hC0000004, 0);
        din = 32'h99; din_last = 1'b0; din_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", din_ready, 0);
            check("bp_hold", block_out, 128'hC0000004_C0000003_C0000002_C0000001);
        end
        @(posedge clk); #1 block_ready = 1'b1;
        @(posedge clk); #1 idle();
        @(negedge clk);
        check("bp_words", block_words, 1);
        check("bp_out", block_out, 128'h99);
        check("bp_valid", block_valid, 0);
        @(posedge clk); #1;
        send(32'h2, 0); send(32'h3, 0); send(32'h4, 1);
        idle();
        repeat (2) @(posedge clk); #1;

        // Back-to-back: 12 words, last on word 12
        b0 = blk_cnt; l0 = last_cnt;
        for (int i = 1; i <= 12; i++) send(32'h1000 + i, (i == 12));
        idle();
        repeat (3) @(posedge clk); #1;
        check("b2b_blocks", blk_cnt - b0, 3);
        check("b2b_lastcnt", last_cnt - l0, 1);
        check("b2b_lastidx", last_idx, b0 + 3);

        // Single-word last during drain
        block_ready = 1'b0;
        send(32'hD1, 0); send(32'hD2, 0); send(32'hD3, 0); send(32'hD4, 0);
        block_ready = 1'b1; din = 32'h5; din_last = 1'b1; din_valid = 1'b1;
        @(posedge clk); #1 idle(); block_ready = 1'b0;
        @(negedge clk);
        check("drain_valid", block_valid, 1);
        check("drain_words", block_words, 1);
        check("drain_last", block_last, 1);
        check("drain_out", block_out, 128'h5);
        @(posedge clk); #1 block_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-block
        send(32'hE1, 0); send(32'hE2, 0);
        idle(); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_out", block_out, 0);
        check("mrst_words", block_words, 0);
        check("mrst_valid", block_valid, 0);
        @(posedge clk); #1;
        send(32'hF1, 0); send(32'hF2, 0); send(32'hF3, 0); send(32'hF4, 0);
        idle();
        @(negedge clk);
        check("mrst_clean", block_out, 128'hF4_000000F3_000000F2_000000F1);
        check("mrst_cwords", block_words, 4);
        repeat (3) @(posedge clk); #1;
        check("sb_drained", sb.size(), 0);

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
